// File: rtl/ifu_ibuf_pkg.sv
// Shared constants and the buffered entry type for the fetch-to-decode instruction buffer.
`ifndef IFU_IBUF_DEFINES
`define IFU_IBUF_DEFINES
`define INST_NOP       32'h0000_0013
`define STALL_WIDTH    6
`define STALL_IF       1
`define CPU_RESET_ADDR 32'h0000_0000
`endif

package ifu_ibuf_pkg;

   localparam logic [31:0] INST_NOP       = `INST_NOP;
   localparam int          STALL_WIDTH    = `STALL_WIDTH;
   localparam int          STALL_IF       = `STALL_IF;
   localparam logic [31:0] CPU_RESET_ADDR = `CPU_RESET_ADDR;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ibuf_entry_t;

endpackage

// File: rtl/ifu_ibuf_if.sv
// Fetch/decode-facing signal bundle of the instruction buffer.
interface ifu_ibuf_if
   import ifu_ibuf_pkg::*;
#(
   parameter int DEPTH = 4
);
   localparam int PTR_W = $clog2(DEPTH);

   logic                   flush_i;
   logic [STALL_WIDTH-1:0] stall_i;
   logic [31:0]            inst_i;
   logic [31:0]            pc_i;
   logic                   inst_valid_i;
   logic                   full_o;
   logic [31:0]            inst_o;
   logic [31:0]            pc_o;
   logic                   inst_valid_o;
   logic                   id_ready_i;
   logic [PTR_W:0]         level_o;

   modport slave (
      input  flush_i, stall_i, inst_i, pc_i, inst_valid_i, id_ready_i,
      output full_o, inst_o, pc_o, inst_valid_o, level_o
   );

   modport master (
      output flush_i, stall_i, inst_i, pc_i, inst_valid_i, id_ready_i,
      input  full_o, inst_o, pc_o, inst_valid_o, level_o
   );

endinterface

// File: rtl/ifu_ibuf_fifo.sv
// Generic synchronous FIFO core; occupancy is tracked by a counter so pointers may wrap freely.
module ibuf_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wrData,
   output logic [WIDTH-1:0] o_rdData,
   output logic [PTR_W:0]   o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W:0]   r_count;

   // Storage carries no reset: contents are never visible while the count is zero.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) begin
         r_mem[r_wrPtr] <= i_wrData;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (i_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdData = r_mem[r_rdPtr];
   assign o_count  = r_count;

endmodule

// File: rtl/ifu_ibuf.sv
// Instruction buffer between fetch and decode: queues {inst, pc} pairs and presents the oldest.
module ifu_ibuf
   import ifu_ibuf_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input logic       clk,
   input logic       rst_n,
   ifu_ibuf_if.slave bus
);

   localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(DEPTH);

   ibuf_entry_t    w_wrEntry;
   ibuf_entry_t    w_rdEntry;
   logic [PTR_W:0] w_count;
   logic           w_full;
   logic           w_valid;
   logic           w_push;
   logic           w_pop;

   // Full and valid come only from the registered count, so fetch never sees id_ready_i ripple through.
   assign w_full  = (w_count == LEVEL_FULL);
   assign w_valid = (w_count != '0);

   assign w_push = bus.inst_valid_i & ~w_full & ~bus.flush_i;
   assign w_pop  = w_valid & bus.id_ready_i & ~bus.stall_i[STALL_IF] & ~bus.flush_i;

   assign w_wrEntry.inst = bus.inst_i;
   assign w_wrEntry.pc   = bus.pc_i;

   ibuf_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(ibuf_entry_t))
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_flush  (bus.flush_i),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_wrData (w_wrEntry),
      .o_rdData (w_rdEntry),
      .o_count  (w_count)
   );

   assign bus.full_o       = w_full;
   assign bus.inst_valid_o = w_valid;
   assign bus.inst_o       = w_valid ? w_rdEntry.inst : INST_NOP;
   assign bus.pc_o         = w_valid ? w_rdEntry.pc   : 32'h0;
   assign bus.level_o      = w_count;

endmodule
